ysyx_210544_cmt_stage: RTL

Commit stage: the consumer (responder) end of the writeback stage's `writebacked` req/ack handshake. It accepts one writeback result per transaction and writes the integer register file. It also emits a one-cycle difftest commit record and maintains retired-instruction and cycle counters. It sits after the writeback stage, feeding the regfile write port and the difftest/commit monitors; it also detects the simulation trap instruction and halts.

---
 rtl/ysyx_210544_cmt_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_210544_cmt_stage.sv
// Commit stage: responds to the writeback req/ack handshake, writes the regfile,
// emits a one-cycle difftest commit record and keeps instret/cycle counters.
module ysyx_210544_cmt_stage #(
  parameter logic [31:0] TRAP_INST = 32'h0000_006b
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmt_writebacked_req,
  output logic        o_cmt_writebacked_ack,
  input  logic [63:0] i_cmt_pc,
  input  logic [31:0] i_cmt_inst,
  input  logic [4:0]  i_cmt_rd,
  input  logic        i_cmt_rd_wen,
  input  logic [63:0] i_cmt_rd_wdata,
  input  logic        i_cmt_skipcmt,
  input  logic [31:0] i_cmt_intrNo,
  output logic        o_rf_wen,
  output logic [4:0]  o_rf_waddr,
  output logic [63:0] o_rf_wdata,
  output logic        o_cmt_valid,
  output logic [63:0] o_cmt_pc,
  output logic [31:0] o_cmt_inst,
  output logic        o_cmt_wen,
  output logic [4:0]  o_cmt_wdest,
  output logic [63:0] o_cmt_wdata,
  output logic        o_cmt_skip,
  output logic [31:0] o_cmt_intrNo,
  output logic [63:0] o_cmt_instret,
  output logic [63:0] o_cmt_cycle,
  output logic        o_cmt_halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_HALT   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_capture;
  logic        w_commit;
  logic        w_is_intr;
  logic        w_is_trap;
  logic        w_valid;
  logic        w_rf_wen;
  logic        w_retire;

  logic [63:0] r_pc;
  logic [31:0] r_inst;
  logic [4:0]  r_rd;
  logic        r_rd_wen;
  logic [63:0] r_rd_wdata;
  logic        r_skip;
  logic [31:0] r_intr;
  logic [63:0] r_instret;
  logic [63:0] r_cycle;

  assign w_commit  = (r_state == S_COMMIT);
  assign w_is_intr = (r_intr != 32'd0);
  assign w_is_trap = (r_inst == TRAP_INST) && !w_is_intr;
  assign w_valid   = w_commit && ((r_inst != 32'd0) || w_is_intr);
  assign w_rf_wen  = w_commit && r_rd_wen && (r_rd != 5'd0) && !w_is_intr;
  assign w_retire  = w_commit && !w_is_intr && (r_inst != 32'd0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; COMMIT lasts exactly one cycle, HALT is terminal
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmt_writebacked_req) begin
          w_capture   = 1'b1;
          w_state_nxt = S_COMMIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_COMMIT: begin
        if (w_is_trap) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Holding registers for the accepted writeback payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= 64'd0;
      r_inst     <= 32'd0;
      r_rd       <= 5'd0;
      r_rd_wen   <= 1'b0;
      r_rd_wdata <= 64'd0;
      r_skip     <= 1'b0;
      r_intr     <= 32'd0;
    end else if (w_capture) begin
      r_pc       <= i_cmt_pc;
      r_inst     <= i_cmt_inst;
      r_rd       <= i_cmt_rd;
      r_rd_wen   <= i_cmt_rd_wen;
      r_rd_wdata <= i_cmt_rd_wdata;
      r_skip     <= i_cmt_skipcmt;
      r_intr     <= i_cmt_intrNo;
    end
  end

  // Retired-instruction and free-running cycle counters (wrap at 2^64)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instret <= 64'd0;
      r_cycle   <= 64'd0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_retire) begin
        r_instret <= r_instret + 64'd1;
      end else begin
        r_instret <= r_instret;
      end
    end
  end

  // Outputs depend only on state and holding registers, so reset clears them at once
  always_comb begin
    o_cmt_writebacked_ack = w_commit;
    o_rf_wen      = w_rf_wen;
    o_rf_waddr    = 5'd0;
    o_rf_wdata    = 64'd0;
    o_cmt_valid   = w_valid;
    o_cmt_pc      = 64'd0;
    o_cmt_inst    = 32'd0;
    o_cmt_wen     = 1'b0;
    o_cmt_wdest   = 5'd0;
    o_cmt_wdata   = 64'd0;
    o_cmt_skip    = 1'b0;
    o_cmt_intrNo  = 32'd0;
    o_cmt_instret = r_instret;
    o_cmt_cycle   = r_cycle;
    o_cmt_halted  = (r_state == S_HALT);
    if (w_rf_wen) begin
      o_rf_waddr = r_rd;
      o_rf_wdata = r_rd_wdata;
    end else begin
      o_rf_waddr = 5'd0;
      o_rf_wdata = 64'd0;
    end
    if (w_valid) begin
      o_cmt_pc     = r_pc;
      o_cmt_inst   = r_inst;
      o_cmt_wen    = w_rf_wen;
      o_cmt_wdest  = w_rf_wen ? r_rd : 5'd0;
      o_cmt_wdata  = w_rf_wen ? r_rd_wdata : 64'd0;
      o_cmt_skip   = r_skip;
      o_cmt_intrNo = r_intr;
    end else begin
      o_cmt_pc     = 64'd0;
    end
  end

endmodule
